grayscale: RTL and testbench

//  Converts a packed 24-bit RGB pixel stream into the 8-bit gray stream consumed by the Sobel stage.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_pipe.sv | 59 +++++
 rtl/grayscale.sv | 103 ++++++++++
 tb/tb_grayscale.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and constants for the grayscale conversion block.
// The optional luma weighting is selected by GRAYSCALE_LUMA_EN (see gray_pipe).
package gray_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_FLUSH = 2'd1,
        S_DONE  = 2'd2
    } gray_state_t;

    localparam logic [19:0] DIV3_MUL   = 20'd683;
    localparam int          DIV3_SHIFT = 11;
    localparam logic [15:0] LUMA_R     = 16'd77;
    localparam logic [15:0] LUMA_G     = 16'd150;
    localparam logic [15:0] LUMA_B     = 16'd29;

    // Multiply-shift equals floor(sum/3) exactly over the whole 0..765 range.
    function automatic logic [7:0] div3(input logic [9:0] sum);
        logic [19:0] prod;
        prod = {10'd0, sum} * DIV3_MUL;
        return prod[DIV3_SHIFT +: 8];
    endfunction

endpackage

// File: rtl/gray_pipe.sv
// Two-stage RGB-to-gray datapath with valid bits; the whole pipe moves only on advance.
// GRAYSCALE_LUMA_EN selects BT.601-style weights instead of the plain average.
module gray_pipe
    import gray_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        advance,
    input  logic        in_valid,
    input  logic [23:0] in_rgb,
    output logic        out_valid,
    output logic [7:0]  out_gray
);

`ifdef GRAYSCALE_LUMA_EN
    localparam int S1_W = 16;
`else
    localparam int S1_W = 10;
`endif

    logic            s1_valid_q;
    logic            s2_valid_q;
    logic [S1_W-1:0] s1_data_q;
    logic [S1_W-1:0] s1_data_d;
    logic [7:0]      s2_data_q;
    logic [7:0]      s2_data_d;

    // Stage results computed from the current inputs / stage-1 register.
    always_comb begin
`ifdef GRAYSCALE_LUMA_EN
        s1_data_d = LUMA_R * {8'd0, in_rgb[23:16]}
                  + LUMA_G * {8'd0, in_rgb[15:8]}
                  + LUMA_B * {8'd0, in_rgb[7:0]};
        s2_data_d = s1_data_q[15:8];
`else
        s1_data_d = {2'b00, in_rgb[23:16]} + {2'b00, in_rgb[15:8]} + {2'b00, in_rgb[7:0]};
        s2_data_d = div3(s1_data_q);
`endif
    end

    // Pipeline registers; a stall freezes both stages together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= 8'd0;
        end else if (advance) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            s1_data_q  <= s1_data_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_gray  = s2_valid_q ? s2_data_q : 8'd0;

endmodule

// File: rtl/grayscale.sv
// Frame-counting RGB-to-gray stage between two show-ahead FIFOs; pulses done per frame.
// Define GRAYSCALE_LUMA_EN for luma weighting; handshake and timing are unchanged.
module grayscale
    import gray_pkg::*;
#(
    parameter int IMG_WIDTH  = 540,
    parameter int IMG_HEIGHT = 720
)
(
    input  logic        clock,
    input  logic        reset,
    output logic        rgb_rd_en,
    input  logic        rgb_empty,
    input  logic [23:0] rgb_dout,
    output logic        gray_wr_en,
    input  logic        gray_full,
    output logic [7:0]  gray_din,
    output logic        done
);

    localparam int          FRAME_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam logic [19:0] LAST_PIX  = 20'(FRAME_PIX - 1);

    gray_state_t state_q;
    gray_state_t state_d;
    logic [19:0] cnt_q;
    logic [19:0] cnt_d;
    logic        done_q;
    logic        done_d;
    logic        s1_busy_q;
    logic        s2_valid_s;
    logic        advance_s;

    assign advance_s  = !s2_valid_s || !gray_full;
    assign rgb_rd_en  = !reset && (state_q == S_RUN) && !rgb_empty && advance_s;
    assign gray_wr_en = s2_valid_s && !gray_full;
    assign done       = done_q;

    gray_pipe u_pipe (
        .clock     (clock),
        .reset     (reset),
        .advance   (advance_s),
        .in_valid  (rgb_rd_en),
        .in_rgb    (rgb_dout),
        .out_valid (s2_valid_s),
        .out_gray  (gray_din)
    );

    // Frame sequencing: count pops, wait for the pipe to drain, then one done cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_RUN: begin
                if (rgb_rd_en) begin
                    cnt_d = cnt_q + 20'd1;
                    if (cnt_q == LAST_PIX) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_FLUSH: begin
                if (!s1_busy_q && !s2_valid_s) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FLUSH;
                end
            end
            S_DONE: begin
                state_d = S_RUN;
                cnt_d   = 20'd0;
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = 20'd0;
            end
        endcase
    end

    // Shadow of the stage-1 valid bit so the drain check needs no extra pipe port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_RUN;
            cnt_q     <= 20'd0;
            done_q    <= 1'b0;
            s1_busy_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (advance_s) begin
                s1_busy_q <= rgb_rd_en;
            end
        end
    end

endmodule

// File: tb/tb_grayscale.sv
// Directed bench for grayscale on a 4x2 frame with FIFO models and a gray scoreboard.
module tb_grayscale;

    localparam int W = 4;
    localparam int H = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rgb_rd_en;
    logic        rgb_empty = 1'b1;
    logic [23:0] rgb_dout = 24'h0;
    logic        gray_wr_en;
    logic        gray_full = 1'b0;
    logic [7:0]  gray_din;
    logic        done;

    grayscale #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .rgb_rd_en  (rgb_rd_en),
        .rgb_empty  (rgb_empty),
        .rgb_dout   (rgb_dout),
        .gray_wr_en (gray_wr_en),
        .gray_full  (gray_full),
        .gray_din   (gray_din),
        .done       (done)
    );

    always #5 clock = ~clock;

    logic [23:0] rgb_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  wlog[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pop_count = 0;
    int wr_count = 0;
    int done_cnt = 0;
    int first_pop_cyc = -1;
    int first_wr_cyc = -1;
    int pop9_cyc = -1;
    int done1_cyc = -1;
    int pop_at_done = 0;
    int wr_at_done = 0;
    bit rd_fire = 1'b0;
    bit wr_fire = 1'b0;
    logic [7:0] din_s = 8'h0;
    bit full_force = 1'b0;
    bit rand_mode = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [23:0] p);
        int v;
`ifdef GRAYSCALE_LUMA_EN
        v = 77 * p[23:16] + 150 * p[15:8] + 29 * p[7:0];
        return 8'(v >> 8);
`else
        v = p[23:16] + p[15:8] + p[7:0];
        return 8'(v / 3);
`endif
    endfunction

    task automatic push(input logic [23:0] p);
        rgb_q.push_back(p);
        exp_q.push_back(model(p));
    endtask

    function automatic int sel_val(input int which);
        if (which == 0) return done_cnt;
        else if (which == 1) return pop_count;
        else return wr_count;
    endfunction

    // Wait (bounded) until done count / pop count / write count reaches n.
    task automatic wait_sel(input int which, input int n, input int maxc, input string tag);
        int k = 0;
        while (sel_val(which) < n && k < maxc) begin
            @(posedge clock); #3;
            k++;
        end
        if (sel_val(which) < n) check_eq(tag, sel_val(which), n);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clock); #3; end
    endtask

    // Sample handshakes mid-cycle, away from the active edge.
    always @(negedge clock) begin
        cyc++;
        rd_fire = rgb_rd_en;
        wr_fire = gray_wr_en;
        din_s   = gray_din;
        if (rgb_rd_en && first_pop_cyc < 0) first_pop_cyc = cyc;
        if (gray_wr_en && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (rgb_rd_en && pop_count == 8 && pop9_cyc < 0) pop9_cyc = cyc;
        if (done) begin
            done_cnt++;
            pop_at_done = pop_count;
            wr_at_done  = wr_count;
            if (done1_cyc < 0) done1_cyc = cyc;
        end
    end

    // FIFO models: apply last cycle's pop/push, then present next cycle's inputs.
    always @(posedge clock) begin
        #1;
        if (rd_fire) begin
            if (rgb_q.size() > 0) void'(rgb_q.pop_front());
            pop_count++;
        end
        if (wr_fire) begin
            wr_count++;
            wlog.push_back(din_s);
            if (exp_q.size() == 0) check_eq("extra_write", 1, 0);
            else check_eq("gray", din_s, exp_q.pop_front());
        end
        gray_full = full_force || (rand_mode && $urandom_range(0, 2) == 0);
        rgb_empty = (rgb_q.size() == 0) || (rand_mode && $urandom_range(0, 3) == 0);
        rgb_dout  = (rgb_q.size() > 0) ? rgb_q[0] : 24'h0;
    end

    initial begin
        logic [7:0] held;
        int r, g, b, rem, w0, d0;

        // Frame 1 plus two pixels of frame 2 queued while reset is held.
        push(24'hFFFFFF); push(24'h000000); push(24'h010203); push(24'hFF0000);
        push(24'h123456); push(24'h808080); push(24'h0A0B0C); push(24'hFEFDFC);
        push(24'h204060); push(24'h332211);
        @(posedge clock); #3;
        check_eq("rst_rd_en", rgb_rd_en, 0);
        check_eq("rst_wr_en", gray_wr_en, 0);
        check_eq("rst_din", gray_din, 0);
        check_eq("rst_done", done, 0);
        reset = 1'b0;

        wait_sel(0, 1, 200, "timeout_frame1");
        wait_sel(1, 10, 50, "timeout_resume");
        check_eq("latency", first_wr_cyc - first_pop_cyc, 2);
`ifdef GRAYSCALE_LUMA_EN
        check_eq("vec0", wlog[0], 8'hFF);
        check_eq("vec1", wlog[1], 8'h00);
        check_eq("vec2", wlog[2], 8'h01);
        check_eq("vec3", wlog[3], 8'h4C);
`else
        check_eq("vec0", wlog[0], 8'hFF);
        check_eq("vec1", wlog[1], 8'h00);
        check_eq("vec2", wlog[2], 8'h02);
        check_eq("vec3", wlog[3], 8'h55);
`endif
        check_eq("f1_writes_at_done", wr_at_done, 8);
        check_eq("f1_pops_at_done", pop_at_done, 8);
        check_eq("resume_after_done", pop9_cyc > done1_cyc, 1);
        check_eq("f1_done_count", done_cnt, 1);

        // Rest of frame 2 and frame 3, with a 5-cycle downstream stall.
        for (int i = 0; i < 14; i++) push(24'((i * 24'h0B1D2F) ^ 24'h5A5A5A));
        wait_sel(2, 12, 100, "timeout_prestall");
        full_force = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock); #3;
            check_eq("stall_rd_en", rgb_rd_en, 0);
            check_eq("stall_wr_en", gray_wr_en, 0);
            if (k == 0) held = gray_din;
            else check_eq("stall_din", gray_din, held);
        end
        full_force = 1'b0;
        wait_sel(0, 3, 300, "timeout_frame3");
        check_eq("f3_writes", wr_count, 24);
        check_eq("f3_pops", pop_count, 24);

        // Three frames with random empty/full.
        rand_mode = 1'b1;
        for (int i = 0; i < 24; i++) push(24'($urandom));
        wait_sel(0, 6, 2000, "timeout_random");
        rand_mode = 1'b0;
        idle(10);
        check_eq("rand_done_count", done_cnt, 6);
        check_eq("rand_writes", wr_count, 48);
        check_eq("rand_pops", pop_count, 48);
        check_eq("rand_writes_at_done", wr_at_done, 48);

        // Every sum 0..765 (two zero pads complete the last frame).
        for (int s = 0; s < 768; s++) begin
            r   = (s > 765) ? 0 : ((s > 255) ? 255 : s);
            rem = (s > 765) ? 0 : s - r;
            g   = (rem > 255) ? 255 : rem;
            b   = rem - g;
            push({8'(r), 8'(g), 8'(b)});
        end
        wait_sel(0, 102, 5000, "timeout_sums");
        check_eq("sums_writes", wr_count, 816);
        check_eq("sums_done_count", done_cnt, 102);

        // Reset with two pixels held in the pipe.
        full_force = 1'b1;
        push(24'h0F0F0F); push(24'hF0F0F0);
        wait_sel(1, 818, 50, "timeout_inflight");
        idle(2);
        check_eq("inflight_unwritten", exp_q.size(), 2);
        exp_q.delete();
        w0 = wr_count;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(24'(32'h00103050 + i * 32'h00112233));
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #3;
            check_eq("midrst_rd_en", rgb_rd_en, 0);
            check_eq("midrst_wr_en", gray_wr_en, 0);
        end
        check_eq("midrst_no_writes", wr_count, w0);
        reset = 1'b0;
        full_force = 1'b0;
        wait_sel(0, d0 + 1, 200, "timeout_postrst");
        idle(10);
        check_eq("postrst_writes", wr_count, w0 + 8);
        check_eq("postrst_done", done_cnt, d0 + 1);
        check_eq("postrst_pops", pop_count, 826);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
